// File: rtl/regarb_pkg.sv
// Shared types and widths for the regfile access arbiter between the processor
// and the test/debug port.
package regarb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   typedef enum logic [1:0] {
      PROC   = 2'd0,
      DRAIN  = 2'd1,
      ACCESS = 2'd2,
      ACK    = 2'd3
   } arbState_e;

   function automatic logic testOwns(input arbState_e s);
      return (s == ACCESS) || (s == ACK);
   endfunction

endpackage

// File: rtl/regarb_sat_counter.sv
// Loadable up/down counter that sticks at MAX when counting up and at zero when
// counting down; load wins over inc, inc wins over dec.
module regarb_sat_counter #(
   parameter int            W   = 4,
   parameter logic [W-1:0]  MAX = '1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] loadValue,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = W'(1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (inc && (count != MAX)) begin
         count <= count + ONE;
      end else if (dec && (count != '0)) begin
         count <= count - ONE;
      end
   end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Hands the single regfile to the test port through a req/ack handshake, stalling
// the processor at a safe point and bounding both burst length and processor dwell.
module regfile_access_arbiter
   import regarb_pkg::*;
#(
   parameter int HOLD_MAX = 8,
   parameter int PROC_MIN = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  p_we,
   input  logic [REG_ADDR_W-1:0] p_wreg,
   input  logic [REG_DATA_W-1:0] p_wdata,
   input  logic [REG_ADDR_W-1:0] p_rega,
   input  logic [REG_ADDR_W-1:0] p_regb,
   output logic                  p_stall,
   input  logic                  t_req,
   input  logic                  t_we,
   input  logic [REG_ADDR_W-1:0] t_reg,
   input  logic [REG_DATA_W-1:0] t_wdata,
   output logic                  t_gnt,
   output logic                  t_ack,
   output logic [REG_DATA_W-1:0] t_rdata,
   output logic                  r_we,
   output logic [REG_ADDR_W-1:0] r_wreg,
   output logic [REG_ADDR_W-1:0] r_rega,
   output logic [REG_ADDR_W-1:0] r_regb,
   output logic [REG_DATA_W-1:0] r_wdata,
   input  logic [REG_DATA_W-1:0] r_rdataA
);

   localparam int BURST_W = $clog2(HOLD_MAX + 1);
   localparam int DWELL_W = (PROC_MIN > 1) ? $clog2(PROC_MIN) : 1;
   localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(HOLD_MAX);
   // The PROC entry cycle is itself a processor cycle, so the counter holds the
   // number of further PROC cycles still owed before a new DRAIN may start.
   localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'((PROC_MIN > 0) ? PROC_MIN - 1 : 0);

   arbState_e          state;
   arbState_e          nextState;
   logic [BURST_W-1:0] burstCount;
   logic [DWELL_W-1:0] dwellCount;
   logic               dwellLoad;

   // State register; reset drops any access in flight straight back to PROC.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= PROC;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic for the handshake and burst/dwell limits.
   always_comb begin
      nextState = state;
      case (state)
         PROC:    if (t_req && (dwellCount == '0)) nextState = DRAIN;
         DRAIN:   nextState = t_req ? ACCESS : PROC;
         ACCESS:  nextState = ACK;
         ACK:     nextState = (t_req && (burstCount < BURST_CAP)) ? ACCESS : PROC;
         default: nextState = PROC;
      endcase
   end

   assign dwellLoad = (nextState == PROC) && ((state == ACK) || (state == DRAIN));

   regarb_sat_counter #(
      .W   (BURST_W),
      .MAX (BURST_CAP)
   ) burstCounter (
      .clock     (clock),
      .reset     (reset),
      .load      (state == PROC),
      .loadValue ('0),
      .inc       (state == ACCESS),
      .dec       (1'b0),
      .count     (burstCount)
   );

   regarb_sat_counter #(
      .W   (DWELL_W),
      .MAX (DWELL_LOAD)
   ) dwellCounter (
      .clock     (clock),
      .reset     (reset),
      .load      (dwellLoad),
      .loadValue (DWELL_LOAD),
      .inc       (1'b0),
      .dec       (state == PROC),
      .count     (dwellCount)
   );

   assign p_stall = (state != PROC);
   assign t_gnt   = testOwns(state);
   assign t_ack   = (state == ACK);

   // Regfile port steering; DRAIN keeps forwarding so an in-flight write lands.
   always_comb begin
      r_we    = p_we;
      r_wreg  = p_wreg;
      r_wdata = p_wdata;
      r_rega  = p_rega;
      r_regb  = p_regb;
      case (state)
         ACCESS: begin
            r_we    = t_we;
            r_wreg  = t_reg;
            r_wdata = t_wdata;
            r_rega  = t_reg;
         end
         ACK: begin
            r_we = 1'b0;
         end
         default: begin
         end
      endcase
   end

   // Read result is captured as ACCESS ends and held until the next test read.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         t_rdata <= '0;
      end else if ((state == ACCESS) && !t_we) begin
         t_rdata <= r_rdataA;
      end
   end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed and randomized checks of the regfile access arbiter against a small
// regfile and a cycle-schedule model of the handshake.
module tb_regfile_access_arbiter;

   localparam int HOLD_MAX = 8;
   localparam int PROC_MIN = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        p_we = 1'b0;
   logic [4:0]  p_wreg = '0;
   logic [31:0] p_wdata = '0;
   logic [4:0]  p_rega = '0;
   logic [4:0]  p_regb = '0;
   logic        p_stall;
   logic        t_req = 1'b0;
   logic        t_we = 1'b0;
   logic [4:0]  t_reg = '0;
   logic [31:0] t_wdata = '0;
   logic        t_gnt;
   logic        t_ack;
   logic [31:0] t_rdata;
   logic        r_we;
   logic [4:0]  r_wreg;
   logic [4:0]  r_rega;
   logic [4:0]  r_regb;
   logic [31:0] r_wdata;
   logic [31:0] r_rdataA;

   logic [31:0] rf [32] = '{default: 32'h0};
   logic [31:0] shadow [32];
   logic        stallTrace [40];
   logic        ackTrace [40];

   int cyc = 0;
   int checkCount = 0;
   int passCount = 0;
   int failCount = 0;
   int idx, len1, acks1, gap, totalAcks, start1;
   int reqCycle, ackCycle, expAckCycle, lastProcEntry, gapLen;
   logic        gotAck, rndWe;
   logic [4:0]  rndReg;
   logic [31:0] rndData, lastRead, expRead;

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      if (r_we && (r_wreg != 5'd0)) rf[r_wreg] <= r_wdata;
   end

   assign r_rdataA = (r_rega == 5'd0) ? 32'h0 : rf[r_rega];

   regfile_access_arbiter #(
      .HOLD_MAX (HOLD_MAX),
      .PROC_MIN (PROC_MIN)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .p_we     (p_we),
      .p_wreg   (p_wreg),
      .p_wdata  (p_wdata),
      .p_rega   (p_rega),
      .p_regb   (p_regb),
      .p_stall  (p_stall),
      .t_req    (t_req),
      .t_we     (t_we),
      .t_reg    (t_reg),
      .t_wdata  (t_wdata),
      .t_gnt    (t_gnt),
      .t_ack    (t_ack),
      .t_rdata  (t_rdata),
      .r_we     (r_we),
      .r_wreg   (r_wreg),
      .r_rega   (r_rega),
      .r_regb   (r_regb),
      .r_wdata  (r_wdata),
      .r_rdataA (r_rdataA)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      t_req = 1'b0;
      repeat (n) tick();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Flags are {p_stall, t_gnt, t_ack}.
   task automatic checkFlags(input string tag, input logic [2:0] expected);
      checkOutput(tag, {29'd0, p_stall, t_gnt, t_ack}, {29'd0, expected});
   endtask

   task automatic applyStimulus(input logic we, input logic [4:0] rg, input logic [31:0] data);
      t_req   = 1'b1;
      t_we    = we;
      t_reg   = rg;
      t_wdata = data;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset values; ports must follow the processor even while in reset.
      p_we = 1'b1; p_wreg = 5'd4; p_wdata = 32'h44;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkFlags("reset flags", 3'b000);
      checkOutput("reset t_rdata", t_rdata, 32'h0);
      checkOutput("reset r_we", {31'd0, r_we}, 32'd1);
      checkOutput("reset r_wreg", {27'd0, r_wreg}, 32'd4);
      tick();
      p_we = 1'b0;
      reset = 1'b1;
      idle(3);

      // Single write.
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF);
      @(negedge clock); checkFlags("wr c0", 3'b000);
      tick(); @(negedge clock); checkFlags("wr c1", 3'b100);
      tick(); @(negedge clock); checkFlags("wr c2", 3'b110);
      checkOutput("wr c2 r_we", {31'd0, r_we}, 32'd1);
      checkOutput("wr c2 r_wreg", {27'd0, r_wreg}, 32'd5);
      checkOutput("wr c2 r_wdata", r_wdata, 32'hDEADBEEF);
      tick(); @(negedge clock); checkFlags("wr c3", 3'b111);
      t_req = 1'b0;
      tick(); @(negedge clock); checkFlags("wr c4", 3'b000);
      p_rega = 5'd5; #1;
      checkOutput("wr readback", r_rdataA, 32'hDEADBEEF);
      idle(6);

      // Single read with hold.
      p_we = 1'b1; p_wreg = 5'd7; p_wdata = 32'h12345678;
      tick();
      p_we = 1'b0;
      idle(5);
      applyStimulus(1'b0, 5'd7, 32'h0);
      tick();
      tick(); @(negedge clock);
      checkOutput("rd c2 r_rega", {27'd0, r_rega}, 32'd7);
      checkOutput("rd c2 r_we", {31'd0, r_we}, 32'd0);
      tick(); @(negedge clock); checkFlags("rd c3", 3'b111);
      checkOutput("rd t_rdata", t_rdata, 32'h12345678);
      t_req = 1'b0;
      repeat (5) tick();
      p_rega = 5'd5;
      @(negedge clock);
      checkOutput("rd t_rdata held", t_rdata, 32'h12345678);
      idle(6);

      // Processor write in flight when the request arrives.
      applyStimulus(1'b1, 5'd9, 32'h55);
      p_we = 1'b1; p_wreg = 5'd3; p_wdata = 32'hAA;
      @(negedge clock); checkFlags("drain c0", 3'b000);
      tick();
      p_wreg = 5'd2; p_wdata = 32'h22;
      @(negedge clock); checkFlags("drain c1", 3'b100);
      checkOutput("drain r_we", {31'd0, r_we}, 32'd1);
      checkOutput("drain r_wreg", {27'd0, r_wreg}, 32'd2);
      tick();
      p_we = 1'b0;
      @(negedge clock); checkOutput("drain c2 r_wreg", {27'd0, r_wreg}, 32'd9);
      tick(); @(negedge clock); checkFlags("drain c3", 3'b111);
      t_req = 1'b0;
      tick(); @(negedge clock);
      checkOutput("drain rf3", rf[3], 32'hAA);
      checkOutput("drain rf2", rf[2], 32'h22);
      checkOutput("drain rf9", rf[9], 32'h55);
      idle(6);

      // Continuous request: burst cap and processor dwell.
      applyStimulus(1'b0, 5'd7, 32'h0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         stallTrace[i] = p_stall;
         ackTrace[i]   = t_ack;
         if (i < 39) tick();
      end
      t_req = 1'b0;
      idx = 0;
      while (idx < 40 && !stallTrace[idx]) idx++;
      start1 = idx;
      len1 = 0; acks1 = 0;
      while (idx < 40 && stallTrace[idx]) begin
         len1++; acks1 += int'(ackTrace[idx]); idx++;
      end
      gap = 0;
      while (idx < 40 && !stallTrace[idx]) begin gap++; idx++; end
      totalAcks = 0;
      for (int i = 0; i < 40; i++) totalAcks += int'(ackTrace[i]);
      checkOutput("burst start", start1, 32'd1);
      checkOutput("burst stall len", len1, 2 * HOLD_MAX + 1);
      checkOutput("burst acks", acks1, HOLD_MAX);
      checkOutput("burst dwell gap", gap, PROC_MIN);
      checkOutput("burst total acks", totalAcks, 2 * HOLD_MAX);
      tick();
      idle(6);

      // Abort during DRAIN, then dwell enforced.
      applyStimulus(1'b1, 5'd11, 32'hBAD);
      @(negedge clock); checkFlags("abort c0", 3'b000);
      tick();
      t_req = 1'b0;
      @(negedge clock); checkFlags("abort c1", 3'b100);
      checkOutput("abort c1 r_we", {31'd0, r_we}, 32'd0);
      tick(); @(negedge clock); checkFlags("abort c2", 3'b000);
      checkOutput("abort c2 r_we", {31'd0, r_we}, 32'd0);
      t_we = 1'b0;
      t_req = 1'b1;
      for (int k = 3; k <= 5; k++) begin
         tick(); @(negedge clock); checkFlags("abort dwell", 3'b000);
      end
      tick(); @(negedge clock); checkFlags("abort c6 drain", 3'b100);
      tick(); @(negedge clock); checkFlags("abort c7", 3'b110);
      tick(); @(negedge clock); checkFlags("abort c8", 3'b111);
      t_req = 1'b0;
      checkOutput("abort rf11", rf[11], 32'h0);
      tick();
      idle(6);

      // Reset during a write ACCESS.
      p_wreg = 5'd6;
      applyStimulus(1'b1, 5'd13, 32'hCAFEF00D);
      tick();
      tick(); @(negedge clock); checkFlags("rst access", 3'b110);
      #1 reset = 1'b0;
      #1;
      checkFlags("rst flags", 3'b000);
      checkOutput("rst r_we", {31'd0, r_we}, 32'd0);
      checkOutput("rst r_wreg", {27'd0, r_wreg}, 32'd6);
      checkOutput("rst t_rdata", t_rdata, 32'h0);
      t_req = 1'b0;
      tick();
      reset = 1'b1;
      @(negedge clock);
      checkOutput("rst rf13", rf[13], 32'h0);
      tick();
      idle(6);

      // Randomized transactions against a schedule and regfile-contents model.
      for (int i = 0; i < 32; i++) shadow[i] = rf[i];
      lastProcEntry = -1000;
      lastRead = t_rdata;
      for (int n = 0; n < 25; n++) begin
         gapLen = $urandom_range(0, 5);
         for (int g = 0; g < gapLen; g++) begin
            if ($urandom_range(0, 1) == 1) begin
               p_we = 1'b1; p_wreg = 5'($urandom); p_wdata = $urandom;
               if (p_wreg != 5'd0) shadow[p_wreg] = p_wdata;
            end
            tick();
            p_we = 1'b0;
         end
         rndWe = 1'($urandom_range(0, 1));
         rndReg = 5'($urandom);
         rndData = $urandom;
         applyStimulus(rndWe, rndReg, rndData);
         reqCycle = cyc;
         expAckCycle = ((reqCycle > lastProcEntry + PROC_MIN - 1) ? reqCycle : lastProcEntry + PROC_MIN - 1) + 3;
         gotAck = 1'b0;
         for (int w = 0; w < 40 && !gotAck; w++) begin
            @(negedge clock);
            if (t_ack) gotAck = 1'b1;
            else tick();
         end
         ackCycle = cyc;
         checkOutput("rnd ack seen", {31'd0, gotAck}, 32'd1);
         checkOutput("rnd ack cycle", ackCycle, expAckCycle);
         if (!rndWe) begin
            expRead = (rndReg == 5'd0) ? 32'h0 : shadow[rndReg];
            lastRead = expRead;
         end else begin
            expRead = lastRead;
            if (rndReg != 5'd0) shadow[rndReg] = rndData;
         end
         checkOutput("rnd t_rdata", t_rdata, expRead);
         lastProcEntry = ackCycle + 1;
         t_req = 1'b0;
         tick();
      end
      idle(2);
      for (int i = 1; i < 32; i++) checkOutput("rnd rf contents", rf[i], shadow[i]);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
